seg7_scan_ctrl: RTL

//   Scan scheduler for the 8-digit multiplexed 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for an 8-digit multiplexed 7-segment display: digit buffer,
// fixed-period slots with an anti-ghost blank interval and brightness PWM.
module seg7_scan_ctrl #(
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_wr_en,
    input  logic [2:0] i_wr_addr,
    input  logic [4:0] i_wr_data,
    input  logic [7:0] i_dig_en,
    input  logic [3:0] i_bright,
    output logic [7:0] o_seg_d,
    output logic [7:0] o_seg_com,
    output logic [2:0] o_scan_idx,
    output logic       o_slot_tick
);

    localparam int CNT_W   = $clog2(CLK_DIV);
    localparam int LEN_W   = CNT_W + 1;
    localparam int ON_SPAN = CLK_DIV - BLANK_CYC;

    typedef enum logic [1:0] {
        PH_BLANK,
        PH_ON,
        PH_OFF
    } phase_e;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [4:0]       dig_buf_q [8];
    logic [4:0]       dig_buf_d [8];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       shadow_q, shadow_d;
    logic             en_q, en_d;
    logic [LEN_W-1:0] on_len_q, on_len_d;
    logic [7:0]       seg_d_q, seg_d_d;
    logic [7:0]       seg_com_q, seg_com_d;
    logic [2:0]       scan_idx_q, scan_idx_d;
    logic             slot_tick_q, slot_tick_d;

    logic             slot_start;
    logic             slot_end;
    logic [4:0]       bright_p1;
    logic [LEN_W+3:0] on_prod;
    logic [LEN_W-1:0] cnt_ext;
    phase_e           phase;

    // NOTE: combinational logic uses blocking '=' with a default for every
    // output first, so no path leaves a variable unassigned (no latch).
    always_comb begin
        slot_start = (cnt_q == '0);
        slot_end   = (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        idx_d      = slot_end ? idx_q + 3'd1 : idx_q;

        // Scale the usable part of the slot by (bright+1)/16.
        bright_p1  = {1'b0, i_bright} + 5'd1;
        on_prod    = (LEN_W + 4)'(ON_SPAN) * (LEN_W + 4)'(bright_p1);

        shadow_d   = slot_start ? dig_buf_q[idx_q]   : shadow_q;
        en_d       = slot_start ? i_dig_en[idx_q]    : en_q;
        on_len_d   = slot_start ? LEN_W'(on_prod >> 4) : on_len_q;

        dig_buf_d  = dig_buf_q;
        if (i_wr_en) begin
            dig_buf_d[i_wr_addr] = i_wr_data;
        end
    end

    // Phase uses the values latched at cnt==0; BLANK_CYC >= 1 guarantees the
    // stale values from the previous slot are never shown.
    always_comb begin
        cnt_ext = {1'b0, cnt_q};
        phase   = PH_OFF;
        if (cnt_ext < LEN_W'(BLANK_CYC)) begin
            phase = PH_BLANK;
        end else if (cnt_ext < LEN_W'(BLANK_CYC) + on_len_q) begin
            phase = PH_ON;
        end

        seg_d_d     = 8'h00;
        seg_com_d   = 8'hFF;
        if (phase == PH_ON && en_q) begin
            seg_d_d   = {shadow_q[4], hex7(shadow_q[3:0])};
            seg_com_d = ~(8'b1 << idx_q);
        end
        scan_idx_d  = idx_q;
        slot_tick_d = slot_start;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values; the buffer is cleared too because a defined power-on
    // display (all digits '0') is part of the block's behaviour.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < 8; i++) begin
                dig_buf_q[i] <= 5'h00;
            end
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shadow_q    <= 5'h00;
            en_q        <= 1'b0;
            on_len_q    <= '0;
            seg_d_q     <= 8'h00;
            seg_com_q   <= 8'hFF;
            scan_idx_q  <= 3'd0;
            slot_tick_q <= 1'b0;
        end else begin
            dig_buf_q   <= dig_buf_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            en_q        <= en_d;
            on_len_q    <= on_len_d;
            seg_d_q     <= seg_d_d;
            seg_com_q   <= seg_com_d;
            scan_idx_q  <= scan_idx_d;
            slot_tick_q <= slot_tick_d;
        end
    end

    assign o_seg_d     = seg_d_q;
    assign o_seg_com   = seg_com_q;
    assign o_scan_idx  = scan_idx_q;
    assign o_slot_tick = slot_tick_q;

endmodule
